// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch front end with a circular fetch queue.
//
// Fetches one word per cycle from a combinational instruction memory at the
// internal fetch PC (fpc) and buffers {pc, instr} pairs in a DEPTH-entry FIFO.
// Decode consumes the head entry with a valid/ready handshake. A redirect from
// EX flushes the queue and restarts fetch at the word-aligned target.
//
// Parameters:
//   DEPTH     queue entries (2, 4 or 8)
//   RESET_PC  fetch address after reset
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_addr         instruction-memory read address (= fpc)
//   imem_rdata        instruction word at imem_addr, same cycle
//   redirect          taken branch/jump, flushes the queue
//   redirect_pc       redirect target
//   dec_ready         decode accepts the head entry
//   dec_valid         head entry valid
//   dec_instr         head instruction
//   dec_pc            head PC
//   dec_pc_plus4      dec_pc + 4 (mod 2^32)
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds saturating 32-bit
// counters fetch_cnt (pushes), stall_cnt (dec_valid && !dec_ready cycles)
// and flush_cnt (redirects).
module fetch_stage #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [31:0]   fpc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic          push;
  logic          pop;

  assign imem_addr = fpc;
  assign dec_valid = (count != '0);
  assign pop       = dec_valid && dec_ready;
  // A full queue can still accept a word when the head leaves this cycle.
  assign push      = !redirect && ((count < FULL) || pop);

  // ---- fetch -> queue boundary ----
  // Control state: reset and redirect both restart fetch with an empty queue.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc    <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      fpc    <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fpc    <= fpc + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries data only and is never cleared.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      q_pc[wr_ptr]    <= fpc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

  // ---- queue -> decode boundary ----
  assign dec_pc       = q_pc[rd_ptr];
  assign dec_instr    = q_instr[rd_ptr];
  assign dec_pc_plus4 = dec_pc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push)                   fetch_cnt <= sat_inc(fetch_cnt);
      if (dec_valid && !dec_ready) stall_cnt <= sat_inc(stall_cnt);
      if (redirect)               flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DEPTH, default 4, sets the fetch-queue entries; legal values are 2, 4 and 8.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  32  instruction-memory read address, always equal to the internal fetch PC (fpc).
REQ-006 imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle (combinational memory).
REQ-007 redirect  input  1  taken branch/jump from EX; flushes the queue.
REQ-008 redirect_pc  input  32  target address, sampled when redirect=1.
REQ-009 dec_ready  input  1  decode accepts the head entry this cycle.
REQ-010 dec_valid  output  1  head entry valid.
REQ-011 dec_instr  output  32  head instruction.
REQ-012 dec_pc  output  32  head PC.
REQ-013 dec_pc_plus4  output  32  dec_pc+4, modulo 2^32.

Function
REQ-014 The queue is a circular FIFO of {pc, instr} entries with read/write pointers and an occupancy count of 0..DEPTH; dec_valid = (count != 0); all dec_* outputs are driven from the head entry.
REQ-015 Pop occurs when dec_valid && dec_ready; push occurs when !redirect && (count<DEPTH || pop), writing {fpc, imem_rdata} and setting fpc <= fpc+4.
REQ-016 Latency: an instruction fetched in cycle N appears on dec_* no earlier than cycle N+1; throughput is one instruction per cycle when dec_ready=1.
REQ-017 Full (count=DEPTH) with no pop: no push, fpc and imem_addr hold.
REQ-018 Simultaneous push and pop: count is unchanged and both pointers advance.
REQ-019 Redirect has priority over push: count <= 0, pointers reset, fpc <= {redirect_pc[31:2],2'b00}, no push that cycle.
REQ-020 A pop coinciding with redirect completes as a transfer; decode is responsible for killing it.
REQ-021 Following redirect, dec_valid=0 for exactly one cycle; the target instruction appears on dec_* in the second cycle after redirect.
REQ-022 fpc wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-023 Pointers wrap modulo DEPTH.

Reset
REQ-024 On rst=1 at a clock edge, count, pointers <= 0 and fpc <= RESET_PC; rst overrides redirect and any handshake in flight, including mid-stall and mid-flush.
REQ-025 During and immediately after reset, dec_valid=0 and imem_addr=RESET_PC.
REQ-026 In the cycle after reset, dec_instr, dec_pc and dec_pc_plus4 are don't-care while dec_valid=0.
REQ-027 Queue storage is not cleared by reset.

Configuration
REQ-028 With macro FETCH_PERF_CNT_EN defined, the block adds three 32-bit saturating output counters:
- fetch_cnt: increments on each push.
- stall_cnt: increments each cycle with dec_valid && !dec_ready.
- flush_cnt: increments on each redirect.
All three reset to 0 and hold at 32'hFFFF_FFFF.
REQ-029 Without FETCH_PERF_CNT_EN, the counters and their ports are absent and all other behaviour is identical.

Verification
REQ-030 Reset released, dec_ready=1, imem_rdata=imem_addr -> dec_valid rises one cycle after reset with dec_pc=0, then dec_pc=4, 8, 0xC on consecutive cycles, dec_instr=dec_pc.
REQ-031 Hold dec_ready=0 for 10 cycles with DEPTH=4 -> count saturates at 4, imem_addr holds 0x10, dec_pc holds 0; then dec_ready=1 -> dec_pc sequence 0, 4, 8, 0xC, 0x10 with no bubble.
REQ-032 With 3 entries queued, redirect=1 and redirect_pc=0x100 -> next cycle dec_valid=0 and imem_addr=0x100; the cycle after, dec_valid=1 and dec_pc=0x100.
REQ-033 redirect_pc=0x103 -> imem_addr=0x100.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> dec_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, and dec_pc_plus4=0 when dec_pc=FFFF_FFFC.
REQ-035 With FETCH_PERF_CNT_EN: 5 stall cycles and 2 redirects after reset -> stall_cnt=5, flush_cnt=2; assert rst mid-stall -> all counters read 0 the next cycle.
